// File: rtl/mcp3_fifo512x025_ctl.sv
// Control stage for a 512x25 block-RAM FIFO: push-to-RAM writes, RAM reads into a 2-entry prefetch, valid/ready pop.
// Optional sticky overflow flag enabled by defining MCP3_FIFO512X025_ERRCHK_EN.
module mcp3_fifo512x025_ctl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [24:0] push_data,
  output logic        full,
  output logic [9:0]  level,
  output logic        pop_valid,
  output logic [24:0] pop_data,
  input  logic        pop_ready,
  output logic        overflow_err,
  output logic        ram_wren,
  output logic [8:0]  ram_wrad,
  output logic [24:0] ram_data,
  output logic        ram_rden,
  output logic [8:0]  ram_rdad,
  input  logic [24:0] ram_q
);

  localparam logic [9:0] DEPTH = 10'd512;

  logic [8:0]  r_wr_ptr;
  logic [8:0]  r_rd_ptr;
  logic [9:0]  r_level;
  logic        r_inflight;
  logic [1:0]  r_out_cnt;
  logic [24:0] r_slot0;
  logic [24:0] r_slot1;

  logic        w_full;
  logic        w_push_acc;
  logic        w_pop_fire;
  logic [2:0]  w_occ;
  logic        w_rden;
  logic [1:0]  w_out_cnt_next;
  logic [24:0] w_slot0_next;
  logic [24:0] w_slot1_next;

  assign w_full     = (r_level == DEPTH);
  // Gated by reset_n so the write strobe sits at its reset value while reset is held.
  assign w_push_acc = reset_n & push & ~w_full;
  assign w_pop_fire = (r_out_cnt != 2'd0) & pop_ready;

  // Prefetch occupancy after this edge, counting the pop leaving now, so a read can overlap every pop.
  assign w_occ  = {1'b0, r_out_cnt} + {2'b00, r_inflight} - {2'b00, w_pop_fire};
  assign w_rden = (w_occ < 3'd2) & (r_level != 10'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 9'd0;
    end else if (w_push_acc) begin
      r_wr_ptr <= r_wr_ptr + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr   <= 9'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rden;
      if (w_rden) begin
        r_rd_ptr <= r_rd_ptr + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= 10'd0;
    end else if (w_push_acc && !w_rden) begin
      r_level <= r_level + 10'd1;
    end else if (!w_push_acc && w_rden) begin
      r_level <= r_level - 10'd1;
    end
  end

  // Slot 0 is the head; slot 1 is the skid entry behind it.
  always_comb begin
    w_out_cnt_next = r_out_cnt;
    w_slot0_next   = r_slot0;
    w_slot1_next   = r_slot1;
    unique case ({r_inflight, w_pop_fire})
      2'b10: begin
        if (r_out_cnt == 2'd0) begin
          w_slot0_next = ram_q;
        end else begin
          w_slot1_next = ram_q;
        end
        w_out_cnt_next = r_out_cnt + 2'd1;
      end
      2'b01: begin
        w_slot0_next   = r_slot1;
        w_out_cnt_next = r_out_cnt - 2'd1;
      end
      2'b11: begin
        if (r_out_cnt == 2'd1) begin
          w_slot0_next = ram_q;
        end else begin
          w_slot0_next = r_slot1;
          w_slot1_next = ram_q;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_cnt <= 2'd0;
      r_slot0   <= 25'd0;
      r_slot1   <= 25'd0;
    end else begin
      r_out_cnt <= w_out_cnt_next;
      r_slot0   <= w_slot0_next;
      r_slot1   <= w_slot1_next;
    end
  end

`ifdef MCP3_FIFO512X025_ERRCHK_EN
  logic r_overflow_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow_err <= 1'b0;
    end else if (push && w_full) begin
      r_overflow_err <= 1'b1;
    end
  end

  assign overflow_err = r_overflow_err;
`else
  assign overflow_err = 1'b0;
`endif

  assign full      = w_full;
  assign level     = r_level;
  assign pop_valid = (r_out_cnt != 2'd0);
  assign pop_data  = r_slot0;
  assign ram_wren  = w_push_acc;
  assign ram_wrad  = r_wr_ptr;
  assign ram_data  = push_data;
  assign ram_rden  = w_rden;
  assign ram_rdad  = r_rd_ptr;

endmodule

// File: tb/tb_mcp3_fifo512x025_ctl.sv
// Directed bench for mcp3_fifo512x025_ctl with a behavioural 512x25 RAM and an in-order scoreboard.
module tb_mcp3_fifo512x025_ctl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        push = 1'b0;
  logic [24:0] push_data = 25'd0;
  logic        pop_ready = 1'b0;
  logic        full;
  logic [9:0]  level;
  logic        pop_valid;
  logic [24:0] pop_data;
  logic        overflow_err;
  logic        ram_wren;
  logic [8:0]  ram_wrad;
  logic [24:0] ram_data;
  logic        ram_rden;
  logic [8:0]  ram_rdad;
  logic [24:0] ram_q = 25'd0;

  logic [24:0] mem [0:511];

  int          checks = 0;
  int          errors = 0;
  int          pop_count = 0;
  logic [24:0] exp_q [$];
  logic        exp_drop = 1'b0;
  logic        prev_stall = 1'b0;
  logic [24:0] prev_data = 25'd0;
  logic        exp_ovf;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_wrad] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_rdad];
  end

  mcp3_fifo512x025_ctl dut (
    .clk(clk), .reset_n(reset_n), .push(push), .push_data(push_data),
    .full(full), .level(level), .pop_valid(pop_valid), .pop_data(pop_data),
    .pop_ready(pop_ready), .overflow_err(overflow_err),
    .ram_wren(ram_wren), .ram_wrad(ram_wrad), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_rdad(ram_rdad), .ram_q(ram_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after an edge, then evaluate at the falling edge.
  task automatic drive(input logic p, input logic [24:0] d, input logic pr);
    push = p;
    push_data = d;
    pop_ready = pr;
    #4;
    if (ram_rden && ram_wren) begin
      checks++;
      assert (ram_rdad !== ram_wrad) else begin
        errors++;
        $error("FAIL collision: rdad 0x%0h wrad 0x%0h", ram_rdad, ram_wrad);
      end
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(pop_valid), 32'd1);
      chk("stall_data", 32'(pop_data), 32'(prev_data));
    end
    if (pop_valid && pop_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL pop_extra: observed pop 0x%0h expected no data", pop_data);
      end
      if (exp_q.size() != 0) begin
        chk("pop_data", 32'(pop_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      pop_count++;
    end
    prev_stall = pop_valid & ~pop_ready;
    prev_data = pop_data;
    if (p && !exp_drop) exp_q.push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic p, input logic [24:0] d, input logic pr);
    drive(p, d, pr);
    tick();
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pop_valid) && n < maxc) begin
      step(1'b0, 25'd0, 1'b1);
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(pop_valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_full", 32'(full), 32'd0);
  endtask

  initial begin
    int steady;
    int pc;
`ifdef MCP3_FIFO512X025_ERRCHK_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif

    // Reset held with push active: outputs must stay at reset values
    reset_n = 1'b0;
    push = 1'b1;
    push_data = 25'h1555555;
    pop_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pop_data", 32'(pop_data), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    chk("rst_rden", 32'(ram_rden), 32'd0);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_rdad", 32'(ram_rdad), 32'd0);
    chk("rst_wrad", 32'(ram_wrad), 32'd0);
    push = 1'b0;
    reset_n = 1'b1;
    tick();
    repeat (3) step(1'b0, 25'd0, 1'b1);
    chk("idle_pop_valid", 32'(pop_valid), 32'd0);
    chk("idle_level", 32'(level), 32'd0);

    // Single push latency
    drive(1'b1, 25'h1ABCDEF, 1'b1);
    chk("single_wren", 32'(ram_wren), 32'd1);
    chk("single_wrad", 32'(ram_wrad), 32'd0);
    tick();
    drive(1'b0, 25'd0, 1'b1);
    chk("single_rden", 32'(ram_rden), 32'd1);
    chk("single_level1", 32'(level), 32'd1);
    chk("single_valid_e1", 32'(pop_valid), 32'd0);
    tick();
    drive(1'b0, 25'd0, 1'b1);
    chk("single_valid_e2", 32'(pop_valid), 32'd0);
    chk("single_level0", 32'(level), 32'd0);
    tick();
    drive(1'b0, 25'd0, 1'b1);
    chk("single_valid", 32'(pop_valid), 32'd1);
    chk("single_data", 32'(pop_data), 32'h1ABCDEF);
    tick();
    chk("single_empty", 32'(exp_q.size()), 32'd0);
    chk("single_valid_after", 32'(pop_valid), 32'd0);

    // Fill to 514 entries with the consumer stalled
    for (int i = 0; i < 514; i++) begin
      step(1'b1, 25'(32'h100000 + i), 1'b0);
      if (i == 512) begin
        chk("fill513_full", 32'(full), 32'd0);
        chk("fill513_level", 32'(level), 32'd511);
      end
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd512);
    chk("fill_head", 32'(pop_data), 32'h100000);
    exp_drop = 1'b1;
    drive(1'b1, 25'h1FFFFFF, 1'b0);
    chk("ovf_wren", 32'(ram_wren), 32'd0);
    tick();
    exp_drop = 1'b0;
    chk("ovf_level", 32'(level), 32'd512);
    chk("ovf_flag", 32'(overflow_err), 32'(exp_ovf));
    pc = pop_count;
    drain(1200);
    chk("fill_drained", 32'(pop_count - pc), 32'd514);

    // Streaming through pointer wrap
    steady = 0;
    for (int i = 0; i < 1200; i++) begin
      pc = pop_count;
      step(1'b1, 25'(i), 1'b1);
      if (i >= 10 && pop_count == pc + 1) steady++;
    end
    chk("wrap_throughput", 32'(steady), 32'd1190);
    drain(100);

    // Random backpressure with continuous push
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 25'(32'h0A0000 + i), 1'($urandom_range(0, 1)));
    end
    drain(1000);

    // Reset mid-stream with a read in flight
    for (int i = 0; i < 102; i++) begin
      step(1'b1, 25'(32'h0B0000 + i), 1'b0);
    end
    chk("mid_level", 32'(level), 32'd100);
    drive(1'b1, 25'h0B0066, 1'b1);
    chk("mid_rden", 32'(ram_rden), 32'd1);
    tick();
    chk("mid_level2", 32'(level), 32'd100);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(pop_valid), 32'd0);
    chk("mid_rst_data", 32'(pop_data), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_rden", 32'(ram_rden), 32'd0);
    chk("mid_rst_wren", 32'(ram_wren), 32'd0);
    chk("mid_rst_wrad", 32'(ram_wrad), 32'd0);
    chk("mid_rst_rdad", 32'(ram_rdad), 32'd0);
    chk("mid_rst_ovf", 32'(overflow_err), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    push = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    tick();
    step(1'b1, 25'h0000005, 1'b1);
    step(1'b1, 25'h0000006, 1'b1);
    step(1'b1, 25'h0000007, 1'b1);
    drain(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcp3_fifo512x025_ctl.md
# mcp3_fifo512x025_ctl

Control stage for the 512x25 block-RAM buffer in the AFP datapath. Converts a strobe-style push interface into RAM write cycles, drives RAM reads, absorbs the RAM's one-cycle read latency with a 2-entry prefetch stage, and presents a valid/ready pop interface downstream. The RAM array is a separate instance; this block drives its write port and consumes its read port.

## Interface
Parameters: none. Depth fixed at 512, width 25.
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- push  in  1  push strobe; no backpressure
- push_data  in  25  push payload
- full  out  1  RAM holds 512 unread entries
- level  out  10  RAM entries not yet read (0..512)
- pop_valid  out  1  pop_data valid
- pop_data  out  25  head-of-FIFO data
- pop_ready  in  1  consumer accepts when pop_valid & pop_ready
- overflow_err  out  1  sticky: push while full (see Configuration)
- ram_wren  out  1  RAM write enable
- ram_wrad  out  9  RAM write address
- ram_data  out  25  RAM write data
- ram_rden  out  1  RAM read enable
- ram_rdad  out  9  RAM read address
- ram_q  in  25  RAM read data, valid one cycle after ram_rden

## Operation
- Write: ram_wren = push & ~full (combinational); ram_wrad = wr_ptr; ram_data = push_data. wr_ptr (9 bits) increments on accepted push, wraps 511->0.
- Push while full: dropped; no RAM write, pointers unchanged.
- Read credit: out_cnt (0..2, entries in prefetch stage) + inflight (0..1) < 2 and level != 0 -> ram_rden = 1, ram_rdad = rd_ptr; rd_ptr increments, wraps 511->0; inflight set next cycle.
- Next cycle ram_q is written into prefetch stage (2-entry FIFO, head = pop_data).
- Pop: pop_valid & pop_ready removes head; skid entry moves to head same edge. Simultaneous pop and ram_q arrival: arrival written to correct slot, out_cnt unchanged.
- level: +1 on accepted push, -1 on ram_rden, unchanged when both. full = (level == 512).
- Collision invariant: ram_rden never issued for an address written in the same cycle (read only when level != 0 before the edge); with full, no write issues. Bench asserts ram_rden & ram_wren -> ram_rdad != ram_wrad.

## Timing
- Reset values: pop_valid 0, pop_data 0, full 0, level 0, overflow_err 0, ram_rden 0, ram_wren 0, ram_rdad 0, ram_wrad 0; pointers, out_cnt, inflight 0. RAM contents not cleared.
- Reset asserted mid-operation: all state cleared immediately; in-flight read and prefetched data discarded; output ports at reset values while reset_n low.
- Latency: push sampled at edge E0 into empty block -> ram_rden high in cycle after E0 -> pop_valid high after E2 (2 cycles).
- Throughput: 1 push/cycle and, with pop_ready held high, 1 pop/cycle sustained.
- pop_data stable while pop_valid & ~pop_ready.
- Total capacity 514 (512 RAM + 2 prefetch); full reflects RAM only.

## Configuration
- MCP3_FIFO512X025_ERRCHK_EN defined: overflow_err sets on any cycle with push & full, held until reset.
- Undefined: overflow_err tied 0; drop behaviour unchanged.

## Test plan
- Reset: hold reset_n low, pulse clk -> all outputs at reset values; release, no push -> pop_valid stays 0, level 0.
- Single push 0x1ABCDEF into empty, pop_ready 1 -> ram_wrad 0, ram_rden at next cycle, pop_valid after 2 cycles with pop_data 0x1ABCDEF, level back to 0.
- Fill: 514 pushes with pop_ready 0 -> full after 514th accepted push (512 in RAM, out_cnt 2), level 512; 515th push dropped, overflow_err 1 (ERRCHK_EN) or 0 (undefined); then drain 514 entries in order.
- Wrap: stream 1200 incrementing values, push and pop_ready every cycle -> in-order output, 1 pop/cycle steady state, pointers wrap cleanly, no collision assertion fires.
- Backpressure: random pop_ready with continuous push -> pop_data stable while stalled, no loss/duplication vs scoreboard.
- Reset mid-stream: assert reset_n with level 100 and read in flight -> outputs reset immediately; after release, first new push 0x0000005 is the first popped value.
